// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs a req/ack fetch handshake with
// instruction memory and feeds if_pc/if_inst into the IF/ID register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_d;
  logic [31:0] if_pc_d, if_inst_d;
  logic        if_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        redir_pending_q, redir_pending_d;
  logic [31:0] redir_target_q, redir_target_d;

  // The address on the bus is the PC itself, so it cannot move mid-request.
  assign mem_addr = pc_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    state_d         = state_q;
    pc_d            = pc_q;
    req_d           = mem_req;
    if_pc_d         = if_pc;
    if_inst_d       = '0;
    if_valid_d      = 1'b0;
    buf_pc_d        = buf_pc_q;
    buf_inst_d      = buf_inst_q;
    redir_pending_d = redir_pending_q;
    redir_target_d  = redir_target_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: begin
        if (mem_ack) begin
          if (branch_flag || redir_pending_q) begin
            // Wrong-path word: drop it; a live redirect beats the latched one.
            pc_d            = branch_flag ? branch_target : redir_target_q;
            redir_pending_d = 1'b0;
          end else if (!stall) begin
            if_pc_d    = pc_q;
            if_inst_d  = mem_rdata;
            if_valid_d = 1'b1;
            pc_d       = pc_q + PC_STEP;
          end else begin
            buf_pc_d   = pc_q;
            buf_inst_d = mem_rdata;
            pc_d       = pc_q + PC_STEP;
            req_d      = 1'b0;
            state_d    = HOLD;
          end
        end else if (branch_flag) begin
          redir_pending_d = 1'b1;
          redir_target_d  = branch_target;
        end
      end
      HOLD: begin
        if (branch_flag) begin
          pc_d    = branch_target;
          req_d   = 1'b1;
          state_d = REQ;
        end else if (!stall) begin
          if_pc_d    = buf_pc_q;
          if_inst_d  = buf_inst_q;
          if_valid_d = 1'b1;
          req_d      = 1'b1;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    if (rst) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      mem_req         <= 1'b0;
      if_pc           <= '0;
      if_inst         <= '0;
      if_valid        <= 1'b0;
      buf_pc_q        <= '0;
      buf_inst_q      <= '0;
      redir_pending_q <= 1'b0;
      redir_target_q  <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      mem_req         <= req_d;
      if_pc           <= if_pc_d;
      if_inst         <= if_inst_d;
      if_valid        <= if_valid_d;
      buf_pc_q        <= buf_pc_d;
      buf_inst_q      <= buf_inst_d;
      redir_pending_q <= redir_pending_d;
      redir_target_q  <= redir_target_d;
    end
  end

endmodule
